// File: rtl/pool_pkg.sv
// Shared definitions for the pooling/conv control units.
// Holds the FSM encoding and the geometry/width helpers used to size ports and counters.
// Pure declarations: no latency, no flow control.
package pool_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } pool_state_t;

  // Bits needed to index n distinct values, never less than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Output side length for a K x K window stepped by S.
  function automatic int size_next(input int ifm, input int k, input int s);
    return (ifm - k) / s + 1;
  endfunction

  // Channel passes needed when `units` channels are handled at once.
  function automatic int groups(input int depth, input int units);
    return (depth + units - 1) / units;
  endfunction

  function automatic int addr_w(input int side);
    return width_of(side * side);
  endfunction

  function automatic int sel_w(input int g);
    return width_of(g + 1);
  endfunction

endpackage

// File: rtl/pool_cu_gen_if.sv
// Bundle between the pooling control unit and its neighbours/datapath.
// master = control unit side, slave = neighbours, memories and datapath.
// Widths are set by the instantiating context to match the control unit geometry.
interface pool_cu_gen_if #(
  parameter int AW  = 4,
  parameter int NAW = 2,
  parameter int SW  = 2
);
  logic           start_from_previous;
  logic           end_from_next;
  logic           mode_avg;
  logic           end_to_previous;
  logic           ifm_enable_read;
  logic [AW-1:0]  ifm_address_read;
  logic           pool_acc_clear;
  logic           pool_acc_enable;
  logic           pool_mode_avg;
  logic           ifm_enable_write_next;
  logic [NAW-1:0] ifm_address_write_next;
  logic           start_to_next;
  logic [SW-1:0]  ifm_sel_next;
  logic           busy;

  modport master (
    input  start_from_previous, end_from_next, mode_avg,
    output end_to_previous, ifm_enable_read, ifm_address_read,
           pool_acc_clear, pool_acc_enable, pool_mode_avg,
           ifm_enable_write_next, ifm_address_write_next,
           start_to_next, ifm_sel_next, busy
  );

  modport slave (
    output start_from_previous, end_from_next, mode_avg,
    input  end_to_previous, ifm_enable_read, ifm_address_read,
           pool_acc_clear, pool_acc_enable, pool_mode_avg,
           ifm_enable_write_next, ifm_address_write_next,
           start_to_next, ifm_sel_next, busy
  );
endinterface

// File: rtl/pool_delay_line.sv
// Fixed-depth shift register for control flags.
// Latency: exactly DEPTH cycles from din_i to dout_o.
// No flow control; asynchronous reset flushes every stage so nothing stale emerges.
module pool_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  // Shift one stage per cycle, cleared on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/pool_cu_gen.sv
// Pooling control unit: scans K x K windows at stride S, drives reads, accumulator controls and result writes.
// Latency: one read per cycle; accumulate flags lag reads by READ_LATENCY, writes by READ_LATENCY+POOL_LATENCY.
// Backpressure: a finished map is held (pending) until the next layer reports idle; new frames wait meanwhile.
module pool_cu_gen
  import pool_pkg::*;
#(
  parameter int IFM_SIZE        = 14,
  parameter int IFM_DEPTH       = 6,
  parameter int NUMBER_OF_UNITS = 3,
  parameter int KERNAL_SIZE     = 2,
  parameter int STRIDE          = 2,
  parameter int READ_LATENCY    = 1,
  parameter int POOL_LATENCY    = 1
) (
  input logic           clk,
  input logic           reset,
  pool_cu_gen_if.master bus
);

  localparam int N   = size_next(IFM_SIZE, KERNAL_SIZE, STRIDE);
  localparam int G   = groups(IFM_DEPTH, NUMBER_OF_UNITS);
  localparam int AW  = addr_w(IFM_SIZE);
  localparam int NAW = addr_w(N);
  localparam int SW  = sel_w(G);
  localparam int CW  = width_of(N);
  localparam int KW  = width_of(KERNAL_SIZE);
  localparam int DW  = width_of(READ_LATENCY + POOL_LATENCY);

  // Address steps: next kernel row, next window column, next window row.
  localparam logic [AW-1:0]  ROW_STEP  = AW'(IFM_SIZE);
  localparam logic [AW-1:0]  COL_STEP  = AW'(STRIDE);
  localparam logic [AW-1:0]  WROW_STEP = AW'(STRIDE * IFM_SIZE);
  localparam logic [CW-1:0]  OMAX      = CW'(N - 1);
  localparam logic [KW-1:0]  KMAX      = KW'(KERNAL_SIZE - 1);
  localparam logic [NAW-1:0] WMAX      = NAW'(N * N - 1);
  localparam logic [SW-1:0]  SMAX      = SW'(G - 1);
  localparam logic [DW-1:0]  DMAX      = DW'(READ_LATENCY + POOL_LATENCY - 1);

  pool_state_t    state_q, state_d;
  logic [KW-1:0]  kc_q, kc_d, kr_q, kr_d;
  logic [CW-1:0]  ocol_q, ocol_d, orow_q, orow_d;
  logic [AW-1:0]  addr_q, addr_d;    // current read address
  logic [AW-1:0]  win_q, win_d;      // top-left of current window
  logic [AW-1:0]  roff_q, roff_d;    // kr * IFM_SIZE
  logic [AW-1:0]  rbase_q, rbase_d;  // orow * S * IFM_SIZE
  logic [DW-1:0]  drain_q, drain_d;
  logic           go;

  logic           start_req_q, pending_q, stn_q, mode_q;
  logic [NAW-1:0] waddr_q;
  logic [SW-1:0]  sel_q;

  logic           rd, first_elem, last_win;
  logic [2:0]     rl_flags;
  logic           wr_strobe, wrap, pend_eff, fire;

  assign rd         = (state_q == ST_READ);
  assign first_elem = rd && (kc_q == '0) && (kr_q == '0);
  assign last_win   = rd && (kc_q == KMAX) && (kr_q == KMAX);

  // State and scan counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      kc_q    <= '0;
      kr_q    <= '0;
      ocol_q  <= '0;
      orow_q  <= '0;
      addr_q  <= '0;
      win_q   <= '0;
      roff_q  <= '0;
      rbase_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      kc_q    <= kc_d;
      kr_q    <= kr_d;
      ocol_q  <= ocol_d;
      orow_q  <= orow_d;
      addr_q  <= addr_d;
      win_q   <= win_d;
      roff_q  <= roff_d;
      rbase_q <= rbase_d;
      drain_q <= drain_d;
    end
  end

  // Next state and incremental address walk (kc fastest, then kr, ocol, orow).
  always_comb begin
    state_d = state_q;
    kc_d    = kc_q;
    kr_d    = kr_q;
    ocol_d  = ocol_q;
    orow_d  = orow_q;
    addr_d  = addr_q;
    win_d   = win_q;
    roff_d  = roff_q;
    rbase_d = rbase_q;
    drain_d = drain_q;
    go      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req_q && !pending_q) begin
          go      = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (kc_q != KMAX) begin
          kc_d   = kc_q + KW'(1);
          addr_d = addr_q + AW'(1);
        end else if (kr_q != KMAX) begin
          kc_d   = '0;
          kr_d   = kr_q + KW'(1);
          roff_d = roff_q + ROW_STEP;
          addr_d = win_q + roff_q + ROW_STEP;
        end else if (ocol_q != OMAX) begin
          kc_d   = '0;
          kr_d   = '0;
          ocol_d = ocol_q + CW'(1);
          roff_d = '0;
          win_d  = win_q + COL_STEP;
          addr_d = win_q + COL_STEP;
        end else if (orow_q != OMAX) begin
          kc_d    = '0;
          kr_d    = '0;
          ocol_d  = '0;
          orow_d  = orow_q + CW'(1);
          roff_d  = '0;
          rbase_d = rbase_q + WROW_STEP;
          win_d   = rbase_q + WROW_STEP;
          addr_d  = rbase_q + WROW_STEP;
        end else begin
          // Last element of the map: rewind for the next frame.
          kc_d    = '0;
          kr_d    = '0;
          ocol_d  = '0;
          orow_d  = '0;
          roff_d  = '0;
          rbase_d = '0;
          win_d   = '0;
          addr_d  = '0;
          drain_d = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DMAX) state_d = ST_IDLE;
        else                 drain_d = drain_q + DW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  pool_delay_line #(.DEPTH(READ_LATENCY), .WIDTH(3)) u_rd_dly (
    .clk    (clk),
    .reset  (reset),
    .din_i  ({last_win, first_elem, rd}),
    .dout_o (rl_flags)
  );

  pool_delay_line #(.DEPTH(POOL_LATENCY), .WIDTH(1)) u_pool_dly (
    .clk    (clk),
    .reset  (reset),
    .din_i  (rl_flags[2]),
    .dout_o (wr_strobe)
  );

  // A wrapping write and an idle next layer in the same cycle hand over directly.
  assign wrap     = wr_strobe && (waddr_q == WMAX);
  assign pend_eff = pending_q || wrap;
  assign fire     = pend_eff && bus.end_from_next;

  // Handshake, mode latch, write address and channel-group bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_req_q <= 1'b0;
      pending_q   <= 1'b0;
      stn_q       <= 1'b0;
      mode_q      <= 1'b0;
      waddr_q     <= '0;
      sel_q       <= '0;
    end else begin
      if (go)                           start_req_q <= 1'b0;
      else if (bus.start_from_previous) start_req_q <= 1'b1;
      if (go) mode_q <= bus.mode_avg;
      if (wr_strobe) waddr_q <= wrap ? '0 : waddr_q + NAW'(1);
      pending_q <= pend_eff && !bus.end_from_next;
      stn_q     <= fire;
      if (fire) sel_q <= (sel_q == SMAX) ? '0 : sel_q + SW'(1);
    end
  end

  assign bus.end_to_previous        = (state_q == ST_IDLE);
  assign bus.busy                   = (state_q != ST_IDLE);
  assign bus.ifm_enable_read        = rd;
  assign bus.ifm_address_read       = addr_q;
  assign bus.pool_acc_enable        = rl_flags[0];
  assign bus.pool_acc_clear         = rl_flags[1];
  assign bus.pool_mode_avg          = mode_q;
  assign bus.ifm_enable_write_next  = wr_strobe;
  assign bus.ifm_address_write_next = waddr_q;
  assign bus.start_to_next          = stn_q;
  assign bus.ifm_sel_next           = sel_q;

endmodule

// File: tb/tb_pool_cu_gen.sv
// Directed bench for pool_cu_gen: 4x4/K2/S2 instance (A) and 5x5/K3/S1 instance (B).
module tb_pool_cu_gen;
  import pool_pkg::*;

  localparam int A_SIZE = 4;
  localparam int A_K    = 2;
  localparam int A_S    = 2;
  localparam int A_N    = size_next(A_SIZE, A_K, A_S);
  localparam int B_SIZE = 5;
  localparam int B_K    = 3;
  localparam int B_S    = 1;
  localparam int B_N    = size_next(B_SIZE, B_K, B_S);
  localparam int GRP    = groups(6, 3);

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_a1 [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

  always #5 clk = ~clk;

  pool_cu_gen_if #(.AW(addr_w(A_SIZE)), .NAW(addr_w(A_N)), .SW(sel_w(GRP))) ifa ();
  pool_cu_gen_if #(.AW(addr_w(B_SIZE)), .NAW(addr_w(B_N)), .SW(sel_w(GRP))) ifb ();

  pool_cu_gen #(.IFM_SIZE(A_SIZE), .IFM_DEPTH(6), .NUMBER_OF_UNITS(3), .KERNAL_SIZE(A_K),
                .STRIDE(A_S), .READ_LATENCY(1), .POOL_LATENCY(1))
    dut_a (.clk(clk), .reset(rst_a), .bus(ifa));

  pool_cu_gen #(.IFM_SIZE(B_SIZE), .IFM_DEPTH(6), .NUMBER_OF_UNITS(3), .KERNAL_SIZE(B_K),
                .STRIDE(B_S), .READ_LATENCY(1), .POOL_LATENCY(1))
    dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bit found;
    int nrd, nwr, w, e, ea;

    ifa.start_from_previous = 1'b0; ifa.end_from_next = 1'b1; ifa.mode_avg = 1'b0;
    ifb.start_from_previous = 1'b0; ifb.end_from_next = 1'b1; ifb.mode_avg = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    #3;
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Reset state
    chk("rst_etp",  32'(ifa.end_to_previous), 32'(1));
    chk("rst_rd",   32'(ifa.ifm_enable_read), 32'(0));
    chk("rst_busy", 32'(ifa.busy), 32'(0));
    chk("rst_en",   32'(ifa.pool_acc_enable), 32'(0));
    chk("rst_clr",  32'(ifa.pool_acc_clear), 32'(0));
    chk("rst_wr",   32'(ifa.ifm_enable_write_next), 32'(0));
    chk("rst_stn",  32'(ifa.start_to_next), 32'(0));
    chk("rst_sel",  32'(ifa.ifm_sel_next), 32'(0));
    chk("rst_mode", 32'(ifa.pool_mode_avg), 32'(0));
    chk("rst_etp_b", 32'(ifb.end_to_previous), 32'(1));
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);

    // Test 1: 4x4, K2 S2 frame
    ifa.start_from_previous = 1'b1;
    @(negedge clk);
    ifa.start_from_previous = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifa.ifm_enable_read) begin found = 1'b1; break; end
    end
    chk("t1_start_timeout", 32'(found), 32'(1));
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      chk("t1_rd", 32'(ifa.ifm_enable_read), 32'(c < 16));
      if (c < 16) chk("t1_raddr", 32'(ifa.ifm_address_read), exp_a1[c]);
      chk("t1_clr", 32'(ifa.pool_acc_clear), 32'(c == 1 || c == 5 || c == 9 || c == 13));
      chk("t1_en",  32'(ifa.pool_acc_enable), 32'(c >= 1 && c <= 16));
      chk("t1_wr",  32'(ifa.ifm_enable_write_next), 32'(c == 5 || c == 9 || c == 13 || c == 17));
      if (c == 5 || c == 9 || c == 13 || c == 17)
        chk("t1_waddr", 32'(ifa.ifm_address_write_next), (c - 5) / 4);
      chk("t1_stn",  32'(ifa.start_to_next), 32'(c == 18));
      chk("t1_etp",  32'(ifa.end_to_previous), 32'(c >= 18));
      chk("t1_busy", 32'(ifa.busy), 32'(c < 18));
    end
    chk("t1_sel", 32'(ifa.ifm_sel_next), 32'(1));

    // Test 2: 5x5, K3 S1 frame
    ifb.start_from_previous = 1'b1;
    @(negedge clk);
    ifb.start_from_previous = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifb.ifm_enable_read) begin found = 1'b1; break; end
    end
    chk("t2_start_timeout", 32'(found), 32'(1));
    nrd = 0; nwr = 0;
    for (int c = 0; c < 86; c++) begin
      if (c > 0) @(negedge clk);
      if (ifb.ifm_enable_read) nrd++;
      if (ifb.ifm_enable_write_next) nwr++;
      chk("t2_rd", 32'(ifb.ifm_enable_read), 32'(c < 81));
      if (c < 81) begin
        w  = c / 9;
        e  = c % 9;
        ea = ((w / B_N) * B_S + e / B_K) * B_SIZE + (w % B_N) * B_S + e % B_K;
        chk("t2_raddr", 32'(ifb.ifm_address_read), ea);
      end
      if (c == 72) chk("t2_lastwin", 32'(ifb.ifm_address_read), 12);
      if (c >= 1 && c <= 81)
        chk("t2_clr", 32'(ifb.pool_acc_clear), 32'((c - 1) % 9 == 0));
      if (c >= 10 && c <= 82 && (c - 10) % 9 == 0) begin
        chk("t2_wr",    32'(ifb.ifm_enable_write_next), 32'(1));
        chk("t2_waddr", 32'(ifb.ifm_address_write_next), (c - 10) / 9);
      end
    end
    chk("t2_nrd", nrd, 81);
    chk("t2_nwr", nwr, 9);
    chk("t2_etp", 32'(ifb.end_to_previous), 32'(1));

    // Test 3: frame finishes while next layer busy
    ifa.end_from_next = 1'b0;
    ifa.start_from_previous = 1'b1;
    @(negedge clk);
    ifa.start_from_previous = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifa.ifm_enable_read) begin found = 1'b1; break; end
    end
    chk("t3_start_timeout", 32'(found), 32'(1));
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifa.end_to_previous) begin found = 1'b1; break; end
    end
    chk("t3_idle_timeout", 32'(found), 32'(1));
    chk("t3_mode_f2", 32'(ifa.pool_mode_avg), 32'(0));
    ifa.mode_avg = 1'b1;
    ifa.start_from_previous = 1'b1;
    @(negedge clk);
    ifa.start_from_previous = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_rd",  32'(ifa.ifm_enable_read), 32'(0));
      chk("t3_hold_stn", 32'(ifa.start_to_next), 32'(0));
    end
    ifa.end_from_next = 1'b1;
    @(negedge clk);
    chk("t3_stn",   32'(ifa.start_to_next), 32'(1));
    chk("t3_no_rd", 32'(ifa.ifm_enable_read), 32'(0));
    chk("t4_sel0",  32'(ifa.ifm_sel_next), 32'(0));
    @(negedge clk);
    chk("t3_rd_go", 32'(ifa.ifm_enable_read), 32'(1));
    chk("t3_addr0", 32'(ifa.ifm_address_read), 32'(0));
    chk("t5_mode1", 32'(ifa.pool_mode_avg), 32'(1));

    // Test 5: mode input toggles mid-frame
    ifa.mode_avg = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 5) chk("t5_mode_mid", 32'(ifa.pool_mode_avg), 32'(1));
      if (ifa.start_to_next) begin found = 1'b1; break; end
    end
    chk("t3_stn_timeout", 32'(found), 32'(1));
    chk("t4_sel1",  32'(ifa.ifm_sel_next), 32'(1));
    chk("t5_mode_end", 32'(ifa.pool_mode_avg), 32'(1));

    // Test 6: reset at the 7th read of a new frame
    ifa.start_from_previous = 1'b1;
    @(negedge clk);
    ifa.start_from_previous = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifa.ifm_enable_read) begin found = 1'b1; break; end
    end
    chk("t6_start_timeout", 32'(found), 32'(1));
    chk("t5_mode_new", 32'(ifa.pool_mode_avg), 32'(0));
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      chk("t6_rd", 32'(ifa.ifm_enable_read), 32'(1));
    end
    chk("t6_addr7", 32'(ifa.ifm_address_read), 32'(6));
    rst_a = 1'b0;
    #1;
    chk("t6_etp",  32'(ifa.end_to_previous), 32'(1));
    chk("t6_rd0",  32'(ifa.ifm_enable_read), 32'(0));
    chk("t6_busy", 32'(ifa.busy), 32'(0));
    chk("t6_en",   32'(ifa.pool_acc_enable), 32'(0));
    chk("t6_clr",  32'(ifa.pool_acc_clear), 32'(0));
    chk("t6_addr", 32'(ifa.ifm_address_read), 32'(0));
    chk("t6_waddr", 32'(ifa.ifm_address_write_next), 32'(0));
    chk("t6_sel",  32'(ifa.ifm_sel_next), 32'(0));
    chk("t6_mode", 32'(ifa.pool_mode_avg), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_post_wr", 32'(ifa.ifm_enable_write_next), 32'(0));
      chk("t6_post_rd", 32'(ifa.ifm_enable_read), 32'(0));
    end
    chk("t6_post_etp", 32'(ifa.end_to_previous), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
